// File: rtl/mem_responder.sv
// Burst memory responder for a cache controller: accepts a block read or
// write-back, inserts LATENCY wait cycles, then moves 4 words at descending offsets.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic [31:0] addr_mem,
  inout  wire  [31:0] data_mem,
  output logic        ready_mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int         BASE_W = ADDR_W - 2;
  localparam logic [7:0] LAT_C  = LATENCY[7:0];

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic              is_write_q, is_write_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [31:0]       mem_q [0:(2**ADDR_W)-1];

  logic              req_s;
  logic              wr_en_s;
  logic              drive_s;
  logic [ADDR_W-1:0] idx_s;
  logic              unused_addr_s;

  assign req_s         = read_mem | write_mem;
  assign idx_s         = {base_q, beat_q};
  assign unused_addr_s = ^{addr_mem[31:ADDR_W+2], addr_mem[3:0]};

  // A dropped request must not commit the beat in flight, nor may a reset edge.
  assign wr_en_s   = (state_q == S_XFER) & is_write_q & req_s & ~reset;
  assign drive_s   = (state_q == S_XFER) & ~is_write_q;
  assign ready_mem = (state_q != S_WAIT);
  assign data_mem  = drive_s ? mem_q[idx_s] : {32{1'bz}};

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    is_write_d = is_write_q;
    base_d     = base_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          state_d    = S_WAIT;
          cnt_d      = LAT_C;
          is_write_d = write_mem;
          base_d     = addr_mem[ADDR_W+1:4];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!req_s) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q <= 8'd1) begin
          state_d = S_XFER;
          cnt_d   = 8'd0;
          beat_d  = 2'd3;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_XFER: begin
        if (!req_s) begin
          state_d = S_IDLE;
          beat_d  = 2'd0;
        end else if (beat_q == 2'd0) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q - 2'd1;
        end
      end
      S_DONE: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      beat_q     <= 2'd0;
      is_write_q <= 1'b0;
      base_q     <= {BASE_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      is_write_q <= is_write_d;
      base_q     <= base_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= data_mem;
    end
  end

endmodule
